// File: rtl/frontend_pll_pkg.sv
// Shared types and arithmetic helpers for the frontend PLL controller.
package frontend_pll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_TRACK  = 2'd2,
    ST_UPDATE = 2'd3
  } pll_state_e;

  // The integrator carries two guard bits above the phase-increment width.
  localparam int INTEG_EXTRA_BITS = 2;

  // Symmetric saturation to +/-(2^(w-1)-1).
  function automatic longint sat_sym(input longint v, input int w);
    longint lim;
    lim = (longint'(1) <<< (w - 1)) - longint'(1);
    if (v > lim) return lim;
    if (v < -lim) return -lim;
    return v;
  endfunction

  function automatic longint clamp_range(input longint v, input longint lo, input longint hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/pll_lock_detector.sv
// Consecutive lock-hit counter; LOCKED asserts once LOCK_COUNT hits in a row are seen.
module pll_lock_detector #(
  parameter int LOCK_COUNT = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic ce_i,
  input  logic clear_i,
  input  logic update_i,
  input  logic hit_i,
  output logic locked_o
);

  localparam int CNT_W = $clog2(LOCK_COUNT + 1);

  logic [CNT_W-1:0] hits_q, hits_d;

  always_comb begin
    hits_d = hits_q;
    if (ce_i) begin
      if (clear_i) begin
        hits_d = '0;
      end else if (update_i) begin
        // A miss drops lock in the same update that observed it.
        if (!hit_i) begin
          hits_d = '0;
        end else if (hits_q != CNT_W'(LOCK_COUNT)) begin
          hits_d = hits_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hits_q <= '0;
    end else begin
      hits_q <= hits_d;
    end
  end

  assign locked_o = (hits_q == CNT_W'(LOCK_COUNT));

endmodule

// File: rtl/frontend_pll_controller.sv
// PI phase-increment controller that steers the DCO until the COS mul-acc term is nulled.
// Lock detection is built only when PLL_CONTROLLER_LOCK_DETECT_EN is defined.
module frontend_pll_controller
  import frontend_pll_pkg::*;
#(
  parameter int PHASE_INCREMENT_BITS = 28,
  parameter int RESULT_MUL_ACC_WIDTH = 36,
  parameter int ERR_SHIFT            = 12,
  parameter int ERR_WIDTH            = 20,
  parameter int KP_SHIFT             = 2,
  parameter int KI_SHIFT             = 6,
  parameter int UPDATE_PERIOD_BITS   = 10,
  parameter int SETTLE_CYCLES        = 256,
  parameter int SETTLE_TOLERANCE     = 64,
  parameter logic [PHASE_INCREMENT_BITS-1:0] MIN_PHASE_INCREMENT = 28'h0100000,
  parameter logic [PHASE_INCREMENT_BITS-1:0] MAX_PHASE_INCREMENT = 28'h4000000,
  parameter int LOCK_THRESHOLD       = 32,
  parameter int LOCK_COUNT           = 8
) (
  input  logic                                   CLK,
  input  logic                                   RESET_N,
  input  logic                                   CE,
  input  logic                                   ENABLE,
  input  logic                                   START,
  input  logic [PHASE_INCREMENT_BITS-1:0]        START_PHASE_INCREMENT,
  input  logic signed [RESULT_MUL_ACC_WIDTH-1:0] SIN_MUL_ACC,
  input  logic signed [RESULT_MUL_ACC_WIDTH-1:0] COS_MUL_ACC,
  input  logic [PHASE_INCREMENT_BITS-1:0]        CURRENT_PHASE_INCREMENT,
  output logic [PHASE_INCREMENT_BITS-1:0]        PHASE_INCREMENT_OUT,
  output logic signed [ERR_WIDTH-1:0]            PHASE_ERROR,
  output logic                                   UPDATED,
  output logic                                   LOCKED,
  output logic                                   BUSY,
  output pll_state_e                             DBG_STATE
);

  localparam int     PIB          = PHASE_INCREMENT_BITS;
  localparam int     INTEG_W      = PIB + INTEG_EXTRA_BITS;
  localparam int     SETTLE_CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam longint MIN_L        = longint'(MIN_PHASE_INCREMENT);
  localparam longint MAX_L        = longint'(MAX_PHASE_INCREMENT);
  localparam longint TOL_L        = longint'(SETTLE_TOLERANCE);

  pll_state_e                  state_q, state_d;
  logic signed [INTEG_W-1:0]   integ_q, integ_d;
  logic [PIB-1:0]              out_q, out_d;
  logic signed [ERR_WIDTH-1:0] err_q, err_d;
  logic                        updated_q, updated_d;
  logic [SETTLE_CNT_W-1:0]     settle_cnt_q, settle_cnt_d;
  logic [UPDATE_PERIOD_BITS-1:0] period_cnt_q, period_cnt_d;

  logic                        sin_pos;
  logic signed [ERR_WIDTH-1:0] err_sat;
  logic signed [INTEG_W-1:0]   integ_new;
  logic [PIB-1:0]              out_new;
  logic signed [INTEG_W-1:0]   integ_start;
  logic [PIB-1:0]              out_start;
  longint                      fb_diff;
  logic                        fb_ok;
  logic                        settle_done;
  logic                        lock_clear;
  logic                        lock_update;

  // Loop arithmetic runs in 64-bit signed space so clamping happens before any truncation.
  always_comb begin
    sin_pos     = !SIN_MUL_ACC[RESULT_MUL_ACC_WIDTH-1] && (SIN_MUL_ACC != '0);
    err_sat     = ERR_WIDTH'(sat_sym(longint'(COS_MUL_ACC) >>> ERR_SHIFT, ERR_WIDTH));
    integ_new   = INTEG_W'(clamp_range(longint'(integ_q) + longint'(err_sat >>> KI_SHIFT),
                                       MIN_L, MAX_L));
    out_new     = PIB'(clamp_range(longint'(integ_new) + longint'(err_sat >>> KP_SHIFT),
                                   MIN_L, MAX_L));
    integ_start = INTEG_W'(clamp_range(longint'(START_PHASE_INCREMENT), MIN_L, MAX_L));
    out_start   = PIB'(clamp_range(longint'(START_PHASE_INCREMENT), MIN_L, MAX_L));
    fb_diff     = longint'(CURRENT_PHASE_INCREMENT) - longint'(out_q);
    fb_ok       = (fb_diff <= TOL_L) && (fb_diff >= -TOL_L);
    settle_done = (settle_cnt_q == SETTLE_CNT_W'(SETTLE_CYCLES - 1));
  end

  // UPDATED is a one-cycle valid strobe with no ready: PHASE_ERROR and
  // PHASE_INCREMENT_OUT are valid from the edge that raises it and stay held.
  always_comb begin
    state_d      = state_q;
    integ_d      = integ_q;
    out_d        = out_q;
    err_d        = err_q;
    updated_d    = 1'b0;
    settle_cnt_d = settle_cnt_q;
    period_cnt_d = period_cnt_q;
    lock_clear   = 1'b0;
    lock_update  = 1'b0;
    if (CE) begin
      if (!ENABLE) begin
        state_d    = ST_IDLE;
        lock_clear = 1'b1;
      end else if (START) begin
        state_d      = ST_SETTLE;
        integ_d      = integ_start;
        out_d        = out_start;
        settle_cnt_d = '0;
        period_cnt_d = '0;
        lock_clear   = 1'b1;
      end else begin
        case (state_q)
          ST_SETTLE: begin
            if (settle_done && fb_ok) begin
              state_d      = ST_TRACK;
              period_cnt_d = '0;
            end else if (!settle_done) begin
              settle_cnt_d = settle_cnt_q + SETTLE_CNT_W'(1);
            end
          end
          ST_TRACK: begin
            period_cnt_d = period_cnt_q + UPDATE_PERIOD_BITS'(1);
            if (period_cnt_q == '1) state_d = ST_UPDATE;
          end
          ST_UPDATE: begin
            state_d     = ST_TRACK;
            updated_d   = 1'b1;
            lock_update = 1'b1;
            // Wrong half-plane: hold the loop and report a zero error.
            if (sin_pos) begin
              err_d   = err_sat;
              integ_d = integ_new;
              out_d   = out_new;
            end else begin
              err_d = '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      integ_q      <= INTEG_W'(MIN_L);
      out_q        <= MIN_PHASE_INCREMENT;
      err_q        <= '0;
      updated_q    <= 1'b0;
      settle_cnt_q <= '0;
      period_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      integ_q      <= integ_d;
      out_q        <= out_d;
      err_q        <= err_d;
      updated_q    <= updated_d;
      settle_cnt_q <= settle_cnt_d;
      period_cnt_q <= period_cnt_d;
    end
  end

`ifdef PLL_CONTROLLER_LOCK_DETECT_EN
  localparam logic signed [ERR_WIDTH-1:0] LOCK_THR_S = ERR_WIDTH'(LOCK_THRESHOLD);

  logic lock_hit;
  assign lock_hit = sin_pos && (err_sat < LOCK_THR_S) && (err_sat > -LOCK_THR_S);

  pll_lock_detector #(
    .LOCK_COUNT(LOCK_COUNT)
  ) u_lock_detector (
    .clk_i    (CLK),
    .rst_ni   (RESET_N),
    .ce_i     (CE),
    .clear_i  (lock_clear),
    .update_i (lock_update),
    .hit_i    (lock_hit),
    .locked_o (LOCKED)
  );
`else
  assign LOCKED = 1'b0;
`endif

  assign PHASE_INCREMENT_OUT = out_q;
  assign PHASE_ERROR         = err_q;
  assign UPDATED             = updated_q;
  assign BUSY                = (state_q != ST_IDLE);
  assign DBG_STATE           = state_q;

endmodule

// File: tb/tb_frontend_pll_controller.sv
// Randomized scoreboard bench for frontend_pll_controller; follows PLL_CONTROLLER_LOCK_DETECT_EN.
`timescale 1ns/1ps
module tb_frontend_pll_controller;
  import frontend_pll_pkg::*;

  localparam int     PIB         = 28;
  localparam int     RW          = 36;
  localparam int     EW          = 20;
  localparam longint MIN_PI      = 64'h0100000;
  localparam longint MAX_PI      = 64'h4000000;
  localparam longint ERR_LIM     = 524287;
  localparam longint LOCK_THR    = 32;
  localparam int     LOCK_N      = 8;
  localparam int     FIRST_WAIT  = 256 + 1024 + 1;
  localparam int     PERIOD_WAIT = 1024 + 1;
`ifdef PLL_CONTROLLER_LOCK_DETECT_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                 ce = 1'b0;
  logic                 enable = 1'b0;
  logic                 start = 1'b0;
  logic [PIB-1:0]       start_pi = '0;
  logic signed [RW-1:0] sin_acc = '0;
  logic signed [RW-1:0] cos_acc = '0;
  logic [PIB-1:0]       cur_pi = '0;
  logic [PIB-1:0]       phase_out;
  logic [EW-1:0]        phase_err;
  logic                 updated;
  logic                 locked;
  logic                 busy;
  pll_state_e           dbg_state;

  frontend_pll_controller dut (
    .CLK                     (clk),
    .RESET_N                 (rst_n),
    .CE                      (ce),
    .ENABLE                  (enable),
    .START                   (start),
    .START_PHASE_INCREMENT   (start_pi),
    .SIN_MUL_ACC             (sin_acc),
    .COS_MUL_ACC             (cos_acc),
    .CURRENT_PHASE_INCREMENT (cur_pi),
    .PHASE_INCREMENT_OUT     (phase_out),
    .PHASE_ERROR             (phase_err),
    .UPDATED                 (updated),
    .LOCKED                  (locked),
    .BUSY                    (busy),
    .DBG_STATE               (dbg_state)
  );

  // scoreboard state
  int checks = 0;
  int errors = 0;
  int upd_seen = 0;
  logic [PIB+EW:0] exp_q[$];
  logic [PIB+EW:0] mon_e;

  // reference model state
  longint m_integ = MIN_PI;
  longint m_out = MIN_PI;
  int     m_hits = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp_v);
    end
  endtask

  function automatic longint floor_div(input longint v, input longint d);
    if (v >= 0) return v / d;
    return -((-v + d - 1) / d);
  endfunction

  function automatic longint ref_clamp(input longint v);
    if (v < MIN_PI) return MIN_PI;
    if (v > MAX_PI) return MAX_PI;
    return v;
  endfunction

  function automatic longint ref_err(input longint c);
    longint e;
    e = floor_div(c, 4096);
    if (e > ERR_LIM) e = ERR_LIM;
    else if (e < -ERR_LIM) e = -ERR_LIM;
    return e;
  endfunction

  function automatic longint rand_cos(input int cls);
    longint mag;
    case (cls)
      0:       mag = longint'($urandom_range(0, 131071));
      1:       mag = longint'($urandom_range(0, 32'h00FF_FFFF)) * 16;
      default: mag = longint'($urandom) * 7;
    endcase
    return ($urandom_range(0, 1) != 0) ? -mag : mag;
  endfunction

  task automatic model_start(input longint s);
    m_integ = ref_clamp(s);
    m_out   = m_integ;
    m_hits  = 0;
  endtask

  task automatic model_update(input longint s, input longint c);
    longint e;
    if (s <= 0) begin
      e      = 0;
      m_hits = 0;
    end else begin
      e       = ref_err(c);
      m_integ = ref_clamp(m_integ + floor_div(e, 64));
      m_out   = ref_clamp(m_integ + floor_div(e, 4));
      if (e < LOCK_THR && e > -LOCK_THR) m_hits = (m_hits < LOCK_N) ? m_hits + 1 : LOCK_N;
      else m_hits = 0;
    end
    exp_q.push_back({PIB'(m_out), EW'(e), LOCK_EN && (m_hits == LOCK_N)});
  endtask

  // driver tasks
  task automatic idle_cycles(input int n, input bit rand_ce);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ce = rand_ce ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_start(input logic [PIB-1:0] s);
    @(negedge clk);
    enable   = 1'b1;
    ce       = 1'b1;
    start    = 1'b1;
    start_pi = s;
    model_start(longint'(s));
    @(posedge clk);
    #1;
    check("start_out", 64'(phase_out), m_out);
    check("start_busy", 64'(busy), 64'd1);
    @(negedge clk);
    start  = 1'b0;
    cur_pi = PIB'(m_out);
  endtask

  task automatic run_update(input longint s, input longint c, input int exp_n, input bit rand_ce);
    int n;
    bit got;
    sin_acc = RW'(s);
    cos_acc = RW'(c);
    model_update(s, c);
    n   = 0;
    got = 1'b0;
    for (int k = 0; k < 4000 && !got; k++) begin
      if (k > 0) begin
        @(negedge clk);
        ce = rand_ce ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      @(posedge clk);
      if (ce) n++;
      #1;
      if (updated) got = 1'b1;
    end
    check("update_seen", 64'(got), 64'd1);
    check("update_spacing", 64'(n), 64'(exp_n));
  endtask

  // monitor: pops one expected response per UPDATED strobe
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && updated) begin
        upd_seen++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_update: UPDATED=1 with no pending expectation, out=0x%0h", phase_out);
        end else begin
          mon_e = exp_q.pop_front();
          check("upd_out", 64'(phase_out), 64'(mon_e[PIB+EW:EW+1]));
          check("upd_err", 64'(phase_err), 64'(mon_e[EW:1]));
          check("upd_locked", 64'(locked), 64'(mon_e[0]));
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  // main sequence
  initial begin
    longint held;
    int     seen0;
    repeat (3) @(negedge clk);
    check("reset_out", 64'(phase_out), MIN_PI);
    check("reset_err", 64'(phase_err), 64'd0);
    check("reset_updated", 64'(updated), 64'd0);
    check("reset_locked", 64'(locked), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_state", 64'(dbg_state), 64'(ST_IDLE));
    rst_n = 1'b1;

    // clamp to MIN, then hold in SETTLE while feedback is 65 away
    do_start(28'h0000010);
    check("start_clamp_min", 64'(phase_out), 64'h0100000);
    cur_pi = PIB'(m_out + 65);
    seen0  = upd_seen;
    idle_cycles(1600, 1);
    check("settle_hold_busy", 64'(busy), 64'd1);
    check("settle_hold_no_update", 64'(upd_seen - seen0), 64'd0);
    cur_pi = PIB'(m_out + 64);
    run_update(1000, rand_cos(0), 1026, 0);

    // lock acquisition: constant small error, feedback equal to output
    do_start(28'h2000000);
    run_update(1000, 0, FIRST_WAIT, 0);
    check("err0_out_unchanged", 64'(phase_out), 64'h2000000);
    for (int i = 1; i < LOCK_N; i++)
      run_update(longint'($urandom_range(1, 100000)),
                 longint'($urandom_range(0, 258047)) - 126976, PERIOD_WAIT, 1);
    check("locked_after_8", 64'(locked), 64'(LOCK_EN));
    held = m_out;
    run_update(-5, rand_cos(1), PERIOD_WAIT, 0);
    check("miss_locked", 64'(locked), 64'd0);
    check("miss_err", 64'(phase_err), 64'd0);
    check("miss_out_held", 64'(phase_out), held);

    // randomized updates across error magnitudes and half-planes
    for (int i = 0; i < 6; i++) begin
      longint s;
      if ($urandom_range(0, 4) == 0) s = -longint'($urandom_range(0, 1000));
      else s = longint'($urandom_range(1, 32'h7FFF_FFFF));
      run_update(s, rand_cos(int'($urandom_range(0, 2))), PERIOD_WAIT, 1);
    end

    // restart while tracking; known PI step
    do_start(28'h1000000);
    run_update(1000, 64'sd1 <<< 20, FIRST_WAIT, 1);
    check("pi_step_out", 64'(phase_out), 64'h1000044);
    check("pi_step_err", 64'(phase_err), 64'd256);

    // MAX clamp and boundary
    do_start(28'hFFFFFFF);
    check("start_clamp_max", 64'(phase_out), 64'h4000000);
    run_update(1, 64'sd30000000000, FIRST_WAIT, 1);
    check("clamp_max_out", 64'(phase_out), 64'h4000000);
    do_start(28'h4000000);
    check("start_eq_max", 64'(phase_out), 64'h4000000);
    run_update(1, -64'sd30000000000, FIRST_WAIT, 0);

    // MIN boundary and symmetric negative saturation
    do_start(28'h0100000);
    check("start_eq_min", 64'(phase_out), 64'h0100000);
    run_update(1, -64'sd34359738367, FIRST_WAIT, 0);
    check("clamp_min_out", 64'(phase_out), 64'h0100000);
    check("err_sat_neg", 64'(phase_err), 64'h80001);

    // ENABLE dropped during SETTLE
    do_start(28'h0300000);
    idle_cycles(50, 0);
    @(negedge clk);
    enable = 1'b0;
    ce     = 1'b1;
    m_hits = 0;
    @(posedge clk);
    #1;
    check("disable_busy", 64'(busy), 64'd0);
    check("disable_out_held", 64'(phase_out), m_out);
    check("disable_locked", 64'(locked), 64'd0);
    idle_cycles(20, 1);
    check("disable_stays_idle", 64'(busy), 64'd0);
    do_start(28'h0250000);
    run_update(1000, rand_cos(1), FIRST_WAIT, 1);

    // asynchronous reset mid-TRACK
    idle_cycles(300, 0);
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_out", 64'(phase_out), MIN_PI);
    check("areset_err", 64'(phase_err), 64'd0);
    check("areset_updated", 64'(updated), 64'd0);
    check("areset_locked", 64'(locked), 64'd0);
    check("areset_busy", 64'(busy), 64'd0);
    m_integ = MIN_PI;
    m_out   = MIN_PI;
    m_hits  = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_start(28'h0180000);
    run_update(1000, rand_cos(0), FIRST_WAIT, 1);

    @(negedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/frontend_pll_controller.md
# frontend_pll_controller

Closed-loop phase-increment controller that drives the ADC/DAC frontend from the opposite side of its interface. It consumes the filtered SIN/COS mul-acc outputs and the filtered phase-increment feedback, and produces the phase-increment input. The PI loop steers the DCO until the COS (quadrature) component is nulled, which tracks the sensor's resonance. It sits between the frontend and the host register interface.

## Interface

Parameters:

- PHASE_INCREMENT_BITS, 28, width of phase-increment values
- RESULT_MUL_ACC_WIDTH, 36, width of SIN/COS mul-acc inputs
- ERR_SHIFT, 12, arithmetic right shift applied to COS_MUL_ACC to form the error
- ERR_WIDTH, 20, saturated error width
- KP_SHIFT, 2, proportional gain as a right shift of the error
- KI_SHIFT, 6, integral gain as a right shift of the error
- UPDATE_PERIOD_BITS, 10, loop update every 2^N CE cycles
- SETTLE_CYCLES, 256, minimum CE cycles spent in SETTLE
- SETTLE_TOLERANCE, 64, maximum |CURRENT_PHASE_INCREMENT - PHASE_INCREMENT_OUT| allowed to leave SETTLE
- MIN_PHASE_INCREMENT, 28'h0100000, lower clamp
- MAX_PHASE_INCREMENT, 28'h4000000, upper clamp
- LOCK_THRESHOLD, 32, |error| below this counts as a lock hit
- LOCK_COUNT, 8, consecutive hits required to assert LOCKED

Ports:

- CLK in 1: clock
- RESET_N in 1: asynchronous active-low reset
- CE in 1: clock enable; all state, counters and updates advance only when CE=1
- ENABLE in 1: 0 forces IDLE
- START in 1: single-cycle pulse; loads START_PHASE_INCREMENT and begins acquisition
- START_PHASE_INCREMENT in PHASE_INCREMENT_BITS: initial increment, unsigned
- SIN_MUL_ACC in RESULT_MUL_ACC_WIDTH: signed, from frontend
- COS_MUL_ACC in RESULT_MUL_ACC_WIDTH: signed, from frontend
- CURRENT_PHASE_INCREMENT in PHASE_INCREMENT_BITS: filtered feedback from frontend
- PHASE_INCREMENT_OUT out PHASE_INCREMENT_BITS: to frontend PHASE_INCREMENT_IN
- PHASE_ERROR out ERR_WIDTH: last saturated error, signed
- UPDATED out 1: one-cycle pulse per loop update
- LOCKED out 1: lock indicator
- BUSY out 1: 1 in any state except IDLE

## Operation

State machine: IDLE, SETTLE, TRACK, UPDATE.

- **IDLE**: PHASE_INCREMENT_OUT is held. On START & ENABLE & CE:
  - integrator := START_PHASE_INCREMENT, clamped to [MIN, MAX]
  - output := clamped value
  - counters cleared
  - next state SETTLE
- **SETTLE**:
  - counts SETTLE_CYCLES CE cycles
  - exits to TRACK only when the count is done AND |CURRENT_PHASE_INCREMENT - PHASE_INCREMENT_OUT| <= SETTLE_TOLERANCE
  - otherwise stays in SETTLE, with the counter saturated
- **TRACK**:
  - period counter of UPDATE_PERIOD_BITS bits increments on each CE
  - on wrap to 0, go to UPDATE
- **UPDATE** (one CE cycle, then back to TRACK):
  - err = sat_ERR_WIDTH(COS_MUL_ACC >>> ERR_SHIFT)
  - If SIN_MUL_ACC <= 0 (wrong half-plane): err is forced to 0, the integrator is held, and it counts as a lock miss.
  - Otherwise:
    - integ := clamp(integ + (err >>> KI_SHIFT))
    - out := clamp(integ_new + (err >>> KP_SHIFT))
  - The integrator is PHASE_INCREMENT_BITS+2 bits signed; clamping is done before truncation to PHASE_INCREMENT_BITS.
  - UPDATED pulses; PHASE_ERROR := err.
- **Lock detection**:
  - hit counter increments on |err| < LOCK_THRESHOLD and saturates at LOCK_COUNT
  - LOCKED=1 when the counter reaches LOCK_COUNT
  - any miss clears the counter and LOCKED in that same update
- **ENABLE=0** in any state: next CE → IDLE, LOCKED cleared, PHASE_INCREMENT_OUT held.
- **START during a non-IDLE state**: restarts acquisition exactly as from IDLE.

## Timing

- **Reset values**:
  - PHASE_INCREMENT_OUT = MIN_PHASE_INCREMENT
  - PHASE_ERROR = 0
  - UPDATED, LOCKED, BUSY = 0
  - state IDLE
- Reset is asynchronous on assert and synchronous on deassert edge usage; reset mid-acquisition returns all outputs to the reset values immediately.
- **START latency**: PHASE_INCREMENT_OUT is updated on the next CE clock edge; BUSY=1 from the same edge.
- **Update spacing**: UPDATED and PHASE_INCREMENT_OUT change on the same edge, one cycle after the period wrap. Spacing is 2^UPDATE_PERIOD_BITS + 1 CE cycles.
- **Clamp boundary**: a value equal to MIN or MAX passes unchanged.
- **Error saturation**: the error saturates symmetrically at ±(2^(ERR_WIDTH-1)-1).
- CE=0 freezes everything, including UPDATED. A pulse in progress still lasts one cycle only.

## Configuration

- PLL_CONTROLLER_LOCK_DETECT_EN defined: the lock hit counter and LOCKED behave as above.
- Not defined: no counter is implemented, LOCKED is tied to 0, and the lock-hit logic is removed.
- Loop behaviour is identical in both cases.

## Structure

- Package frontend_pll_pkg holds:
  - the state enum (IDLE, SETTLE, TRACK, UPDATE)
  - the integrator width constant
  - the saturate and clamp functions
- Sub-module pll_lock_detector: hit counter and LOCKED, instantiated only under the macro.

## Test plan

- Reset with RESET_N=0 mid-TRACK → all outputs immediately at reset values; BUSY=0.
- START with START_PHASE_INCREMENT=28'h0000010 → PHASE_INCREMENT_OUT=28'h0100000 (clamped); stays in SETTLE while feedback differs by >64.
- Constant COS=0, SIN=1000, feedback equal to output → first UPDATED after 256+1024+1 CE cycles; output unchanged; LOCKED after 8 updates.
- COS = 1<<20 (err = 256), KP_SHIFT=2, KI_SHIFT=6, integ = 28'h1000000 → integ = 28'h1000004, out = 28'h1000044.
- SIN = -5 with LOCKED=1 → LOCKED=0, PHASE_ERROR=0, output held.
- ENABLE dropped during SETTLE → IDLE on the next CE; output held; a subsequent START restarts acquisition.
